// File: rtl/light_emitter_driver.sv
// Burst-modulated emitter LED driver: bursts of a square-wave carrier separated by dark gaps,
// with a one-cycle strobe at each burst end so a receiver can sample its filtered sensor.
module light_emitter_driver #(
  parameter logic [16:0] CARRIER_HALF = 17'd25,
  parameter logic [7:0]  BURST_PULSES = 8'd16,
  parameter logic [16:0] GAP_CYCLES   = 17'd25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        ledDrive,
  output logic        burstActive,
  output logic        sampleStrobe,
  output logic [15:0] burstCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] carrier_q, carrier_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [16:0] gap_q, gap_d;
  logic        led_q, led_d;
  logic        active_q, active_d;
  logic        strobe_q, strobe_d;
  logic [15:0] burst_count_q, burst_count_d;

  // Next-state and next-output logic for the IDLE/BURST/GAP sequencer.
  always_comb begin
    state_d       = state_q;
    carrier_d     = carrier_q;
    pulse_d       = pulse_q;
    gap_d         = gap_q;
    led_d         = led_q;
    active_d      = active_q;
    strobe_d      = 1'b0;
    burst_count_d = burst_count_q;

    case (state_q)
      S_IDLE: begin
        led_d    = 1'b0;
        active_d = 1'b0;
        if (enable) begin
          state_d   = S_BURST;
          led_d     = 1'b1;
          active_d  = 1'b1;
          carrier_d = 17'd0;
          pulse_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BURST: begin
        if (carrier_q == CARRIER_HALF - 17'd1) begin
          carrier_d = 17'd0;
          if (led_q) begin
            led_d   = 1'b0;
            pulse_d = pulse_q + 8'd1;
            // The final low half-period is spent in GAP, not BURST.
            if (pulse_q + 8'd1 == BURST_PULSES) begin
              state_d       = S_GAP;
              active_d      = 1'b0;
              strobe_d      = 1'b1;
              burst_count_d = burst_count_q + 16'd1;
              gap_d         = 17'd0;
            end else begin
              state_d = S_BURST;
            end
          end else begin
            led_d = 1'b1;
          end
        end else begin
          carrier_d = carrier_q + 17'd1;
        end
      end

      S_GAP: begin
        led_d    = 1'b0;
        active_d = 1'b0;
        if (gap_q == GAP_CYCLES - 17'd1) begin
          gap_d = 17'd0;
          if (enable) begin
            state_d   = S_BURST;
            led_d     = 1'b1;
            active_d  = 1'b1;
            carrier_d = 17'd0;
            pulse_d   = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 17'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        led_d    = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the LED dark without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      carrier_q     <= 17'd0;
      pulse_q       <= 8'd0;
      gap_q         <= 17'd0;
      led_q         <= 1'b0;
      active_q      <= 1'b0;
      strobe_q      <= 1'b0;
      burst_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      carrier_q     <= carrier_d;
      pulse_q       <= pulse_d;
      gap_q         <= gap_d;
      led_q         <= led_d;
      active_q      <= active_d;
      strobe_q      <= strobe_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign ledDrive     = led_q;
  assign burstActive  = active_q;
  assign sampleStrobe = strobe_q;
  assign burstCount   = burst_count_q;

endmodule

// File: tb/tb_light_emitter_driver.sv
// Bench for light_emitter_driver: a timeline model (cycles since burst start) checked every
// cycle, plus directed scenarios with literal expectations.
module tb_light_emitter_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic        ledDrive, burstActive, sampleStrobe;
  logic [15:0] burstCount;
  logic        led2, active2, strobe2;
  logic [15:0] count2;

  int n_pass = 0;
  int n_chk  = 0;

  localparam int CH1 = 2, BP1 = 3, G1 = 4;
  localparam int L1  = (2 * BP1 - 1) * CH1;
  localparam int CH2 = 1, BP2 = 1, G2 = 1;
  localparam int L2  = (2 * BP2 - 1) * CH2;

  light_emitter_driver #(.CARRIER_HALF(17'd2), .BURST_PULSES(8'd3), .GAP_CYCLES(17'd4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ledDrive(ledDrive), .burstActive(burstActive),
    .sampleStrobe(sampleStrobe), .burstCount(burstCount)
  );

  light_emitter_driver #(.CARRIER_HALF(17'd1), .BURST_PULSES(8'd1), .GAP_CYCLES(17'd1)) dut_min (
    .clk(clk), .rst_n(rst_n), .enable(enable2),
    .ledDrive(led2), .burstActive(active2),
    .sampleStrobe(strobe2), .burstCount(count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: position within the burst+gap timeline, -1 when idle.
  int          m_pos = -1, m2_pos = -1;
  logic [15:0] m_cnt = 16'd0, m2_cnt = 16'd0;
  logic [15:0] bias = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= -1;  m_cnt <= 16'd0;
      m2_pos <= -1; m2_cnt <= 16'd0;
    end else begin
      if (m_pos < 0 || m_pos + 1 == L1 + G1) m_pos <= enable ? 0 : -1;
      else begin
        m_pos <= m_pos + 1;
        if (m_pos + 1 == L1) m_cnt <= m_cnt + 16'd1;
      end
      if (m2_pos < 0 || m2_pos + 1 == L2 + G2) m2_pos <= enable2 ? 0 : -1;
      else begin
        m2_pos <= m2_pos + 1;
        if (m2_pos + 1 == L2) m2_cnt <= m2_cnt + 16'd1;
      end
    end
  end

  function automatic logic [18:0] exp_out(int pos, int len, int ch, logic [15:0] cnt);
    logic act, led, stb;
    act = (pos >= 0) && (pos < len);
    led = act && (((pos / ch) % 2) == 0);
    stb = (pos == len);
    return {led, act, stb, cnt};
  endfunction

  // Per-cycle comparison of both instances against the model, mid-cycle.
  always @(negedge clk) begin
    chk("model_main", {13'd0, ledDrive, burstActive, sampleStrobe, burstCount},
        {13'd0, exp_out(m_pos, L1, CH1, m_cnt + bias)});
    chk("model_min", {13'd0, led2, active2, strobe2, count2},
        {13'd0, exp_out(m2_pos, L2, CH2, m2_cnt)});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [9:0]  trace;
  logic [5:0]  tr2, st2;
  int          t_s[3];
  logic [15:0] cs[3];
  int          ns, nstrobe;
  logic [15:0] cnt_before;

  initial begin
    t_s = '{0, 0, 0};
    cs  = '{16'd0, 16'd0, 16'd0};
    run(3);
    chk("reset_outputs", {13'd0, ledDrive, burstActive, sampleStrobe, burstCount}, 32'd0);
    rst_n = 1'b1;
    run(2);

    // Single burst
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      trace[10 - i] = ledDrive;
      if (i == 2) enable = 1'b0;
    end
    chk("single_led_trace", {22'd0, trace}, {22'd0, 10'b1100110011});
    step();
    chk("single_strobe_c11", {31'd0, sampleStrobe}, 32'd1);
    chk("single_count", {16'd0, burstCount}, 32'd1);
    step();
    chk("single_strobe_c12", {31'd0, sampleStrobe}, 32'd0);
    run(3);
    chk("single_idle", {30'd0, ledDrive, burstActive}, 32'd0);
    run(5);

    // Continuous enable
    ns = 0;
    enable = 1'b1;
    for (int k = 0; k < 60 && ns < 3; k++) begin
      step();
      if (sampleStrobe) begin
        t_s[ns] = k;
        cs[ns]  = burstCount;
        ns++;
      end
    end
    chk("cont_strobes_seen", ns, 3);
    chk("cont_period_a", t_s[1] - t_s[0], 14);
    chk("cont_period_b", t_s[2] - t_s[1], 14);
    chk("cont_count_step", {16'd0, cs[2] - cs[1]}, 32'd1);
    run(6);
    enable = 1'b0;
    cnt_before = burstCount;
    run(30);
    chk("cont_burst_not_truncated", {16'd0, burstCount}, {16'd0, cnt_before + 16'd1});
    chk("cont_back_idle", {31'd0, burstActive}, 32'd0);

    // Glitchy enable: one-cycle pulse in IDLE
    nstrobe = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sampleStrobe) nstrobe++;
      step();
    end
    chk("glitch_one_strobe", nstrobe, 1);

    // Mid-burst asynchronous reset during cycle 5
    enable = 1'b1;
    step();
    enable = 1'b0;
    run(4);
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", {13'd0, ledDrive, burstActive, sampleStrobe, burstCount}, 32'd0);
    run(2);
    rst_n = 1'b1;
    run(20);
    chk("reset_no_late_strobe", {16'd0, burstCount}, 32'd0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("restart_after_reset", {30'd0, ledDrive, burstActive}, 32'd3);
    run(20);
    chk("restart_count", {16'd0, burstCount}, 32'd1);

    // Minimum parameters
    enable2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tr2[5 - i] = led2;
      st2[5 - i] = strobe2;
    end
    enable2 = 1'b0;
    chk("min_led_trace", {26'd0, tr2}, {26'd0, 6'b101010});
    chk("min_strobe_trace", {26'd0, st2}, {26'd0, 6'b010101});
    run(4);

    // burstCount wrap
    bias = 16'hFFFF - m_cnt;
    force dut.burst_count_q = 16'hFFFF;
    run(2);
    release dut.burst_count_q;
    chk("wrap_preload", {16'd0, burstCount}, 32'h0000FFFF);
    enable = 1'b1;
    step();
    enable = 1'b0;
    run(16);
    chk("wrap_to_zero", {16'd0, burstCount}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
